// File: rtl/logic_unit_seq_pkg.sv
// Shared definitions for the sliced logic unit: op encodings, FSM states and
// a helper that sizes the slice counter.
package logic_unit_defs;

    // Operation select; every 3-bit code is a legal operation.
    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOR   = 3'b011,
        OP_NAND  = 3'b100,
        OP_XNOR  = 3'b101,
        OP_ANDN  = 3'b110,
        OP_PASSA = 3'b111
    } op_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The slice counter needs clog2(n) bits, but never fewer than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logic_unit_seq_slice.sv
// Combinational bitwise operation on one SLICE-bit slice of the operands.
module logic_slice
    import logic_unit_defs::*;
#(
    parameter int SLICE = 8
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    // Select the operation; PASSA is also the fallback value.
    always_comb begin
        y = a;
        case (op_t'(op))
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOR:   y = ~(a | b);
            OP_NAND:  y = ~(a & b);
            OP_XNOR:  y = ~(a ^ b);
            OP_ANDN:  y = a & ~b;
            OP_PASSA: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-op bitwise logic unit that processes WIDTH-bit operands one SLICE-bit
// slice per cycle, with valid/ready handshakes on both sides and a zero flag.
module logic_unit_seq
    import logic_unit_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = cnt_width(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("logic_unit_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] result_reg;
    logic             acc_reg;
    logic             zero_reg;

    logic [SLICE-1:0] a_slices [NSLICE];
    logic [SLICE-1:0] b_slices [NSLICE];
    logic [SLICE-1:0] a_sel;
    logic [SLICE-1:0] b_sel;
    logic [SLICE-1:0] slice_y;
    logic             acc_next;

    // Split the latched operands into slice-indexed views.
    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_split
            assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
            assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    // Route the slice addressed by the counter into the single slice unit.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_reg == CW'(i)) begin
                a_sel = a_slices[i];
                b_sel = b_slices[i];
            end
        end
    end

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op (op_reg),
        .a  (a_sel),
        .b  (b_sel),
        .y  (slice_y)
    );

    assign acc_next = acc_reg | (|slice_y);

    // Sequencer: latch on accept, write one slice per RUN cycle, hold in DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            acc_reg    <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        op_reg     <= op;
                        cnt_reg    <= '0;
                        result_reg <= '0;
                        acc_reg    <= 1'b0;
                        zero_reg   <= 1'b0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (cnt_reg == CW'(i)) begin
                            result_reg[i*SLICE +: SLICE] <= slice_y;
                        end
                    end
                    acc_reg <= acc_next;
                    // Counter parks on the last slice rather than wrapping.
                    if (cnt_reg == LAST) begin
                        zero_reg  <= ~acc_next;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign result    = result_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq: vector table through a scoreboard,
// plus backpressure, mid-run reset and single-slice sequences.
module tb_logic_unit_seq;
    import logic_unit_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [2:0]  op;
    logic [31:0] a, b, result;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, zero32, busy32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, result32;

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clock(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(32)) dut32 (
        .clock(clk), .reset_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op32), .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32), .zero(zero32), .busy(busy32)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb32_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Compare the DUT output against the oldest scoreboard entry.
    task automatic sb_compare(input string name, input logic [31:0] res, input logic z);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_result"}, res, e.res);
            chk({name, "_zero"}, z, e.z);
        end
    endtask

    // One transaction on the 8-bit-slice unit; hold > 0 stalls DONE with new
    // operands offered on the input side.
    task automatic issue_op(input string name, input logic [2:0] o, input logic [31:0] aa,
                            input logic [31:0] bb, input logic [31:0] res, input logic z,
                            input int hold);
        int n;
        int lat;
        logic [31:0] r0;
        logic        z0;
        exp_t        e;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = aa; b = bb; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        e.res = res; e.z = z;
        sb_q.push_back(e);
        #1;
        in_valid = 1'b0; op = ~o; a = ~aa; b = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk({name, "_latency"}, lat, 4);
        @(negedge clk);
        r0 = result; z0 = zero;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; op = OP_XOR; a = $urandom; b = $urandom;
            @(negedge clk);
            chk({name, "_hold_valid"}, out_valid, 1);
            chk({name, "_hold_in_ready"}, in_ready, 0);
            chk({name, "_hold_result"}, result, r0);
            chk({name, "_hold_zero"}, zero, z0);
        end
        out_ready = 1'b1;
        if (out_valid && out_ready) sb_compare(name, result, zero);
        else chk({name, "_out_valid"}, out_valid, 1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk({name, "_post_valid"}, out_valid, 0);
        chk({name, "_post_busy"}, busy, 0);
    endtask

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vecs[0]  = '{OP_OR,    32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF, 1'b0};
        vecs[1]  = '{OP_XOR,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[2]  = '{OP_ANDN,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF000_F000, 1'b0};
        vecs[3]  = '{OP_AND,   32'h1234_5678, 32'hFF00_FF00, 32'h1200_5600, 1'b0};
        vecs[4]  = '{OP_NOR,   32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[5]  = '{OP_NOR,   32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000, 1'b1};
        vecs[6]  = '{OP_NAND,  32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0};
        vecs[7]  = '{OP_XNOR,  32'h1234_5678, 32'h1234_0000, 32'hFFFF_A987, 1'b0};
        vecs[8]  = '{OP_PASSA, 32'hCAFE_BABE, 32'h0000_0000, 32'hCAFE_BABE, 1'b0};
        vecs[9]  = '{OP_PASSA, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[10] = '{OP_AND,   32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 1'b0};
        vecs[11] = '{OP_OR,    32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        #12;
        chk("reset_result", result, 0);
        chk("reset_zero", zero, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            issue_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].res, vecs[i].z, 0);
        end

        // Backpressure: DONE stalled five cycles while new operands are offered.
        issue_op("bp_or", OP_OR, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF, 1'b0, 5);

        // Reset after two slices: the in-flight op vanishes.
        @(negedge clk);
        in_valid = 1'b1; op = OP_OR; a = 32'hFFFF_FFFF; b = 32'h0;
        chk("rst_run_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run_result", result, 0);
        chk("rst_run_zero", zero, 0);
        chk("rst_run_out_valid", out_valid, 0);
        chk("rst_run_busy", busy, 0);
        chk("rst_run_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_run_no_valid", out_valid, 0);
        end
        issue_op("rst_nand", OP_NAND, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0);

        // Single-slice unit: one RUN cycle; op change after accept is ignored.
        @(negedge clk);
        in_valid32 = 1'b1; op32 = OP_NOR; a32 = 32'h0; b32 = 32'h0;
        chk("s32_in_ready", in_ready32, 1);
        @(posedge clk);
        e.res = 32'hFFFF_FFFF; e.z = 1'b0;
        sb32_q.push_back(e);
        #1;
        in_valid32 = 1'b0; op32 = OP_AND; a32 = 32'hFFFF_FFFF;
        chk("s32_valid_early", out_valid32, 0);
        @(posedge clk);
        #1;
        chk("s32_latency", out_valid32, 1);
        @(negedge clk);
        out_ready32 = 1'b1;
        if (out_valid32 && sb32_q.size() > 0) begin
            e = sb32_q.pop_front();
            chk("s32_result", result32, e.res);
            chk("s32_zero", zero32, e.z);
        end else begin
            chk("s32_out_valid", out_valid32, 1);
        end
        @(negedge clk);
        out_ready32 = 1'b0;
        chk("s32_post_valid", out_valid32, 0);
        chk("s32_post_busy", busy32, 0);

        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
